// File: rtl/bus_slice_host_pkg.sv
// bus_slice_pkg: shared constants, FSM state type and the slice-index width
// helper for bus_slice_host and its slice register.
//   SLICE_W        pin slice width (8 bits)
//   slice_state_t  IDLE / SHIFT / DRAIN
//   slice_idx_w()  width of the slice index for a LENGTH-bit bus (min 1 bit)
package bus_slice_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } slice_state_t;

    function automatic int slice_idx_w(input int len);
        int slices;
        slices = len / SLICE_W;
        return (slices <= 1) ? 1 : $clog2(slices);
    endfunction

endpackage

// File: rtl/bus_slice_host_if.sv
// bus_slice_host_if: word-level handshake plus pin-side slice signals.
//   wr_valid/wr_ready/wr_data  word to send to the core input bus
//   rd_valid/rd_data           reassembled core output word (one-cycle pulse)
//   frame/pin_out              outbound slice and slice-0 marker
//   pin_in                     returning slice from the wrapper
// Modport slave is the host block; master is its user.
interface bus_slice_host_if #(
    parameter int LENGTH = 16
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [LENGTH-1:0] wr_data;
    logic              rd_valid;
    logic [LENGTH-1:0] rd_data;
    logic              frame;
    logic [7:0]        pin_out;
    logic [7:0]        pin_in;

    modport slave (
        input  wr_valid, wr_data, pin_in,
        output wr_ready, rd_valid, rd_data, frame, pin_out
    );

    modport master (
        output wr_valid, wr_data, pin_in,
        input  wr_ready, rd_valid, rd_data, frame, pin_out
    );
endinterface

// File: rtl/bus_slice_host_shreg.sv
// slice_shreg: LENGTH-bit register addressed in 8-bit slices.
//   clk              clock
//   ld, ld_data      full-word load (takes priority over slice write)
//   wr_en, wr_idx,   write one slice
//   wr_slice
//   rd_idx, rd_slice read one slice of the stored word
//   nxt              value the register takes at the next edge, so the
//                    caller can see a slice written in the current cycle
module slice_shreg
    import bus_slice_pkg::*;
#(
    parameter int LENGTH = 16,
    parameter int IDX_W  = 1
) (
    input  logic              clk,
    input  logic              ld,
    input  logic [LENGTH-1:0] ld_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [7:0]        wr_slice,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [7:0]        rd_slice,
    output logic [LENGTH-1:0] nxt
);
    localparam int SLICES = LENGTH / SLICE_W;

    logic [LENGTH-1:0] q;

    always_comb begin
        nxt = q;
        if (ld) begin
            nxt = ld_data;
        end else if (wr_en) begin
            for (int k = 0; k < SLICES; k++) begin
                if (wr_idx == IDX_W'(k)) nxt[k*SLICE_W +: SLICE_W] = wr_slice;
            end
        end
    end

    always_comb begin
        rd_slice = '0;
        for (int k = 0; k < SLICES; k++) begin
            if (rd_idx == IDX_W'(k)) rd_slice = q[k*SLICE_W +: SLICE_W];
        end
    end

    always_ff @(posedge clk) begin
        q <= nxt;
    end
endmodule

// File: rtl/bus_slice_host.sv
// bus_slice_host: sends a LENGTH-bit word 8 bits per clock on pin_out and
// reassembles the returning slices on pin_in into rd_data.
//   clk, rst   clock; asynchronous active-high reset
//   bus        bus_slice_host_if.slave (word handshake and pin slices)
// Optional (BUS_SLICE_HOST_CMP_EN defined):
//   exp_data      expected returned word, latched at the wr handshake
//   mismatch      high on the rd_valid cycle when the returned word differs
//   mismatch_cnt  saturating count of mismatching words
module bus_slice_host
    import bus_slice_pkg::*;
#(
    parameter int LENGTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    bus_slice_host_if.slave   bus
`ifdef BUS_SLICE_HOST_CMP_EN
    ,
    input  logic [LENGTH-1:0] exp_data,
    output logic              mismatch,
    output logic [15:0]       mismatch_cnt
`endif
);
    localparam int SLICES = LENGTH / SLICE_W;
    localparam int IDX_W  = slice_idx_w(LENGTH);

    slice_state_t      state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  cap_idx;
    logic              cap_vld;
    logic              wr_ready_q;
    logic              rd_valid_q;
    logic [LENGTH-1:0] rd_data_q;
    logic              accept;
    logic [7:0]        tx_slice;
    logic [LENGTH-1:0] rx_nxt;
    logic [LENGTH-1:0] tx_nxt_unused;
    logic [7:0]        rx_slice_unused;

    assign accept = (state == IDLE) && wr_ready_q && bus.wr_valid;

    slice_shreg #(.LENGTH(LENGTH), .IDX_W(IDX_W)) u_tx (
        .clk      (clk),
        .ld       (accept),
        .ld_data  (bus.wr_data),
        .wr_en    (1'b0),
        .wr_idx   ('0),
        .wr_slice (8'h00),
        .rd_idx   (idx),
        .rd_slice (tx_slice),
        .nxt      (tx_nxt_unused)
    );

    // The wrapper registers its output, so pin_in carries the slice that
    // pin_out held one cycle earlier: capture with the delayed index.
    slice_shreg #(.LENGTH(LENGTH), .IDX_W(IDX_W)) u_rx (
        .clk      (clk),
        .ld       (1'b0),
        .ld_data  ('0),
        .wr_en    (cap_vld),
        .wr_idx   (cap_idx),
        .wr_slice (bus.pin_in),
        .rd_idx   ('0),
        .rd_slice (rx_slice_unused),
        .nxt      (rx_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cap_idx    <= '0;
            cap_vld    <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            cap_vld    <= (state == SHIFT);
            cap_idx    <= idx;
            case (state)
                IDLE: begin
                    wr_ready_q <= 1'b1;
                    if (accept) begin
                        idx        <= '0;
                        wr_ready_q <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (idx == IDX_W'(SLICES - 1)) state <= DRAIN;
                    else                           idx   <= idx + 1'b1;
                end
                DRAIN: begin
                    // rx_nxt already holds the last slice being captured now.
                    rd_data_q  <= rx_nxt;
                    rd_valid_q <= 1'b1;
                    wr_ready_q <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.pin_out  = (state == SHIFT) ? tx_slice : 8'h00;
    assign bus.frame    = (state == SHIFT) && (idx == '0);

`ifdef BUS_SLICE_HOST_CMP_EN
    logic [LENGTH-1:0] exp_q;

    always_ff @(posedge clk) begin
        if (accept) exp_q <= exp_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            mismatch <= 1'b0;
            if (state == DRAIN && rx_nxt != exp_q) begin
                mismatch <= 1'b1;
                if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_bus_slice_host.sv
// Directed bench for bus_slice_host: a 16-bit and an 8-bit instance, each
// with a one-cycle registered loopback standing in for the pin-side wrapper.
// Inputs change and outputs are checked at the falling clock edge.
// Builds with or without BUS_SLICE_HOST_CMP_EN.
module tb_bus_slice_host;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] flip = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    bus_slice_host_if #(.LENGTH(16)) b16 ();
    bus_slice_host_if #(.LENGTH(8))  b8 ();

`ifdef BUS_SLICE_HOST_CMP_EN
    logic [15:0] exp16;
    logic [7:0]  exp8;
    logic        mm16, mm8;
    logic [15:0] mc16, mc8;
`endif

    bus_slice_host #(.LENGTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
`ifdef BUS_SLICE_HOST_CMP_EN
        ,
        .exp_data     (exp16),
        .mismatch     (mm16),
        .mismatch_cnt (mc16)
`endif
    );

    bus_slice_host #(.LENGTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
`ifdef BUS_SLICE_HOST_CMP_EN
        ,
        .exp_data     (exp8),
        .mismatch     (mm8),
        .mismatch_cnt (mc8)
`endif
    );

    always #5 clk = ~clk;

    // Wrapper model: registered return path; flip corrupts slice 0 on demand.
    always_ff @(posedge clk) begin
        b16.pin_in <= b16.pin_out ^ (b16.frame ? flip : 8'h00);
        b8.pin_in  <= b8.pin_out;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        b16.wr_valid = 1'b0;
        b16.wr_data  = '0;
        b8.wr_valid  = 1'b0;
        b8.wr_data   = '0;
`ifdef BUS_SLICE_HOST_CMP_EN
        exp16 = '0;
        exp8  = '0;
`endif
        // Reset state
        step();
        step();
        check_val("rst wr_ready", b16.wr_ready, 0);
        check_val("rst rd_valid", b16.rd_valid, 0);
        check_val("rst rd_data",  b16.rd_data,  0);
        check_val("rst frame",    b16.frame,    0);
        check_val("rst pin_out",  b16.pin_out,  0);
`ifdef BUS_SLICE_HOST_CMP_EN
        check_val("rst mismatch",     mm16, 0);
        check_val("rst mismatch_cnt", mc16, 0);
`endif
        rst = 1'b0;
        step();
        check_val("idle wr_ready", b16.wr_ready, 1);
        check_val("idle pin_out",  b16.pin_out,  0);
        check_val("idle8 wr_ready", b8.wr_ready, 1);

        // Single word A55A
        b16.wr_data = 16'hA55A;
        b16.wr_valid = 1'b1;
`ifdef BUS_SLICE_HOST_CMP_EN
        exp16 = 16'hA55A;
`endif
        step();                                   // T+1
        b16.wr_valid = 1'b0;
        check_val("s1 pin_out0", b16.pin_out, 8'h5A);
        check_val("s1 frame0",   b16.frame,   1);
        check_val("s1 wr_ready busy", b16.wr_ready, 0);
        step();                                   // T+2
        check_val("s1 pin_out1", b16.pin_out, 8'hA5);
        check_val("s1 frame1",   b16.frame,   0);
        step();                                   // T+3 DRAIN
        check_val("s1 drain pin_out", b16.pin_out, 0);
        check_val("s1 drain rd_valid", b16.rd_valid, 0);
        step();                                   // T+4
        check_val("s1 rd_valid", b16.rd_valid, 1);
        check_val("s1 rd_data",  b16.rd_data,  16'hA55A);
        check_val("s1 wr_ready", b16.wr_ready, 1);
        step();
        check_val("s1 rd_valid pulse", b16.rd_valid, 0);
        check_val("s1 rd_data hold",   b16.rd_data,  16'hA55A);

        // Back-to-back 1234 then BEEF with wr_valid held
        b16.wr_data = 16'h1234;
        b16.wr_valid = 1'b1;
`ifdef BUS_SLICE_HOST_CMP_EN
        exp16 = 16'h1234;
`endif
        step();                                   // T+1
        b16.wr_data = 16'hBEEF;
        check_val("b2b pin_out0", b16.pin_out, 8'h34);
        step();
        step();
        step();                                   // T+4
        check_val("b2b rd_valid a", b16.rd_valid, 1);
        check_val("b2b rd_data a",  b16.rd_data,  16'h1234);
        check_val("b2b wr_ready",   b16.wr_ready, 1);
`ifdef BUS_SLICE_HOST_CMP_EN
        exp16 = 16'hBEEF;
`endif
        step();                                   // second accept done
        b16.wr_valid = 1'b0;
        check_val("b2b pin_out b0", b16.pin_out, 8'hEF);
        check_val("b2b frame b0",   b16.frame,   1);
        check_val("b2b rd_valid off", b16.rd_valid, 0);
        step();
        check_val("b2b pin_out b1", b16.pin_out, 8'hBE);
        step();
        step();
        check_val("b2b rd_valid b", b16.rd_valid, 1);
        check_val("b2b rd_data b",  b16.rd_data,  16'hBEEF);
`ifdef BUS_SLICE_HOST_CMP_EN
        check_val("b2b mismatch",     mm16, 0);
        check_val("b2b mismatch_cnt", mc16, 0);
`endif

        // Reset during second SHIFT cycle
        step();
        b16.wr_data = 16'hC3C3;
        b16.wr_valid = 1'b1;
        step();                                   // T+1
        b16.wr_valid = 1'b0;
        step();                                   // T+2
        check_val("mid pin_out pre", b16.pin_out, 8'hC3);
        rst = 1'b1;
        #1;
        check_val("mid rst pin_out",  b16.pin_out,  0);
        check_val("mid rst frame",    b16.frame,    0);
        check_val("mid rst rd_data",  b16.rd_data,  0);
        check_val("mid rst wr_ready", b16.wr_ready, 0);
        step();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (b16.rd_valid) pulses++;
        end
        check_val("mid no rd_valid", pulses, 0);
        check_val("mid rd_data 0",   b16.rd_data, 0);
        check_val("mid wr_ready",    b16.wr_ready, 1);
        b16.wr_data = 16'h00FF;
        b16.wr_valid = 1'b1;
`ifdef BUS_SLICE_HOST_CMP_EN
        exp16 = 16'h00FF;
`endif
        step();
        b16.wr_valid = 1'b0;
        check_val("post pin_out0", b16.pin_out, 8'hFF);
        step();
        check_val("post pin_out1", b16.pin_out, 8'h00);
        step();
        step();
        check_val("post rd_valid", b16.rd_valid, 1);
        check_val("post rd_data",  b16.rd_data,  16'h00FF);

        // LENGTH=8 instance
        b8.wr_data = 8'h3C;
        b8.wr_valid = 1'b1;
`ifdef BUS_SLICE_HOST_CMP_EN
        exp8 = 8'h3C;
`endif
        step();                                   // T+1 single SHIFT
        b8.wr_valid = 1'b0;
        check_val("l8 pin_out", b8.pin_out, 8'h3C);
        check_val("l8 frame",   b8.frame,   1);
        step();                                   // T+2 DRAIN
        check_val("l8 drain frame",   b8.frame,   0);
        check_val("l8 drain pin_out", b8.pin_out, 0);
        check_val("l8 drain rd_valid", b8.rd_valid, 0);
        step();                                   // T+3
        check_val("l8 rd_valid", b8.rd_valid, 1);
        check_val("l8 rd_data",  b8.rd_data,  8'h3C);
`ifdef BUS_SLICE_HOST_CMP_EN
        check_val("l8 mismatch", mm8, 0);
`endif

`ifdef BUS_SLICE_HOST_CMP_EN
        // Corrupted return: A55A sent, A55B comes back
        step();
        flip = 8'h01;
        exp16 = 16'hA55A;
        b16.wr_data = 16'hA55A;
        b16.wr_valid = 1'b1;
        step();
        b16.wr_valid = 1'b0;
        step();
        step();
        step();
        check_val("cmp rd_valid",     b16.rd_valid, 1);
        check_val("cmp rd_data",      b16.rd_data,  16'hA55B);
        check_val("cmp mismatch",     mm16, 1);
        check_val("cmp mismatch_cnt", mc16, 1);
        step();
        check_val("cmp mismatch pulse", mm16, 0);
        check_val("cmp cnt hold",       mc16, 1);
        flip = 8'h00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
